lsf_hist_scheduler: RTL and testbench

Ping-pong scheduler for two update_histogram_dmem instances (bank 0, bank 1) in the LSF r-bin histogramming path. It accepts one r-bin stream per event and steers each event to a bank in strict alternation. After each event it drains the bank pipeline, captures the bank's local maximum and returns it tagged with the event ID. It then clears the bank so the other bank can fill meanwhile, giving roughly one event per (RBINS+8) cycles of throughput.

---
 rtl/lsf_hist_scheduler_pkg.sv | 26 ++
 rtl/lsf_hist_scheduler_if.sv | 32 +++
 rtl/lsf_hist_scheduler_bank_ctrl.sv | 178 +++++++++++++++++
 rtl/lsf_hist_scheduler.sv | 98 +++++++++
 tb/tb_lsf_hist_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsf_hist_scheduler_pkg.sv
// Shared types and widths for the LSF r-bin histogram ping-pong scheduler.
// Optional build macro used by the scheduler files: LSF_HIST_TIMEOUT_EN.
package lsf_hist_sched_pkg;

  localparam int HIST_BIN_W = 8;
  localparam int HIST_IDX_W = 7;
  localparam int HIST_CNT_W = 4;
  localparam int EVT_ID_W   = 12;

  typedef enum logic [2:0] {
    ST_PREP,
    ST_CLEAR,
    ST_READY,
    ST_FILL,
    ST_DRAIN,
    ST_DONE
  } bank_state_t;

  typedef struct packed {
    logic [EVT_ID_W-1:0]   evt_id;
    logic [HIST_IDX_W-1:0] rbin;
    logic [HIST_CNT_W-1:0] count;
    logic                  timeout;
  } bank_result_t;

endpackage

// File: rtl/lsf_hist_scheduler_if.sv
// Upstream r-bin stream and downstream result stream of the scheduler.
// master = the surrounding logic, slave = the scheduler itself.
interface lsf_hist_scheduler_if
  import lsf_hist_sched_pkg::*;
#(
  parameter int EVT_W = 12
);

  logic [HIST_BIN_W-1:0] s_bin_tdata;
  logic                  s_bin_tvalid;
  logic                  s_bin_tlast;
  logic                  s_bin_tready;
  logic [EVT_W-1:0]      s_evt_id;

  logic                  res_tvalid;
  logic                  res_tready;
  logic [EVT_W-1:0]      res_evt_id;
  logic [HIST_IDX_W-1:0] res_rbin;
  logic [HIST_CNT_W-1:0] res_count;
  logic                  res_timeout;

  modport master (
    output s_bin_tdata, s_bin_tvalid, s_bin_tlast, s_evt_id, res_tready,
    input  s_bin_tready, res_tvalid, res_evt_id, res_rbin, res_count, res_timeout
  );

  modport slave (
    input  s_bin_tdata, s_bin_tvalid, s_bin_tlast, s_evt_id, res_tready,
    output s_bin_tready, res_tvalid, res_evt_id, res_rbin, res_count, res_timeout
  );

endinterface

// File: rtl/lsf_hist_scheduler_bank_ctrl.sv
// Controller for one histogram bank: clear, fill, drain, hold result.
// With LSF_HIST_TIMEOUT_EN defined, an idle counter force-closes a stalled fill.
module lsf_hist_bank_ctrl
  import lsf_hist_sched_pkg::*;
#(
  parameter int RBINS     = 128,
  parameter int EVT_W     = 12,
  parameter int DRAIN_CYC = 5,
  parameter int TIMEOUT   = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  beat_accept,
  input  logic [HIST_BIN_W-1:0] beat_data,
  input  logic                  beat_last,
  input  logic [EVT_W-1:0]      evt_id,
  input  logic                  res_accept,
  input  logic [HIST_IDX_W-1:0] max_rbin,
  input  logic [HIST_CNT_W-1:0] max_count,
  input  logic                  max_vld,
  output logic [HIST_BIN_W-1:0] bin_tdata,
  output logic                  bin_tvalid,
  output logic                  enable,
  output logic                  reset_rbins,
  output logic                  in_ready,
  output logic                  done,
  output logic                  timeout_close,
  output bank_result_t          result
);

  // The bank needs two extra clear cycles beyond one per bin.
  localparam int CLR_W = $clog2(RBINS + 2);
  localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RBINS + 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);

  bank_state_t      state;
  bank_state_t      state_nxt;
  logic [CLR_W-1:0] clr_cnt;
  logic [DRN_W-1:0] drn_cnt;
  logic             timeout_hit;
  logic             first_beat;

  assign first_beat = (state == ST_READY) && beat_accept;

`ifdef LSF_HIST_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // The TIMEOUT-th consecutive beat-less FILL cycle closes the event.
  assign timeout_hit = (state == ST_FILL) && !beat_accept && (idle_cnt == IDLE_LAST);

  // Count beat-less FILL cycles; any beat or leaving FILL restarts the count.
  always_ff @(posedge clk) begin
    if (rst || (state != ST_FILL) || beat_accept) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_PREP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-state bank controls.
  always_comb begin
    state_nxt     = state;
    enable        = 1'b0;
    reset_rbins   = 1'b0;
    in_ready      = 1'b0;
    done          = 1'b0;
    timeout_close = 1'b0;
    case (state)
      ST_PREP: begin
        state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        reset_rbins = 1'b1;
        if (clr_cnt == CLR_LAST) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        enable   = 1'b1;
        in_ready = 1'b1;
        if (beat_accept) begin
          state_nxt = beat_last ? ST_DRAIN : ST_FILL;
        end
      end
      ST_FILL: begin
        enable   = 1'b1;
        in_ready = 1'b1;
        if (beat_accept && beat_last) begin
          state_nxt = ST_DRAIN;
        end else if (timeout_hit) begin
          state_nxt     = ST_DRAIN;
          timeout_close = 1'b1;
        end
      end
      ST_DRAIN: begin
        enable = 1'b1;
        if (drn_cnt == DRN_LAST) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (res_accept) begin
          state_nxt = ST_PREP;
        end
      end
      default: begin
        state_nxt = ST_PREP;
      end
    endcase
  end

  // Clear and drain cycle counters; PREP zeroes the clear counter.
  always_ff @(posedge clk) begin
    if (rst || (state == ST_PREP)) begin
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + CLR_W'(1);
    end
    if (rst || (state != ST_DRAIN)) begin
      drn_cnt <= '0;
    end else begin
      drn_cnt <= drn_cnt + DRN_W'(1);
    end
  end

  // Forward accepted beats to the bank one cycle later, unmodified.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_tvalid <= 1'b0;
      bin_tdata  <= '0;
    end else begin
      bin_tvalid <= beat_accept;
      if (beat_accept) begin
        bin_tdata <= beat_data;
      end
    end
  end

  // Result register: zeroed and tagged on the first beat, then tracks the bank maximum.
  // Without the timeout feature the timeout flag can never be set.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else begin
      if (first_beat) begin
        result.evt_id <= EVT_ID_W'(evt_id);
        result.rbin   <= '0;
        result.count  <= '0;
      end else if (((state == ST_FILL) || (state == ST_DRAIN)) && max_vld) begin
        result.rbin  <= max_rbin;
        result.count <= max_count;
      end
      if (first_beat) begin
        result.timeout <= 1'b0;
      end else if (timeout_hit) begin
        result.timeout <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsf_hist_scheduler.sv
// Ping-pong scheduler feeding two update_histogram_dmem banks.
// Events alternate between banks; results come back in event order.
// Optional build macro: LSF_HIST_TIMEOUT_EN (idle force-close of a filling event).
module lsf_hist_scheduler
  import lsf_hist_sched_pkg::*;
#(
  parameter int RBINS     = 128,
  parameter int EVT_W     = 12,
  parameter int DRAIN_CYC = 5,
  parameter int TIMEOUT   = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  lsf_hist_scheduler_if.slave        bus,
  output logic [1:0][HIST_BIN_W-1:0] hist_bin_tdata,
  output logic [1:0]                 hist_bin_tvalid,
  output logic [1:0]                 hist_enable,
  output logic [1:0]                 hist_reset_rbins,
  input  logic [1:0][HIST_IDX_W-1:0] hist_max_rbin,
  input  logic [1:0][HIST_CNT_W-1:0] hist_max_count,
  input  logic [1:0]                 hist_max_vld
);

  logic         ip;
  logic         op;
  logic         in_hs;
  logic         out_hs;
  logic [1:0]   bank_ready;
  logic [1:0]   bank_done;
  logic [1:0]   bank_tclose;
  logic [1:0]   beat_accept;
  logic [1:0]   res_accept;
  bank_result_t bank_res [2];

  // No bypass to the idle bank: waiting on bank[ip] keeps events in order.
  assign bus.s_bin_tready = bank_ready[ip];
  assign in_hs  = bus.s_bin_tvalid && bus.s_bin_tready;
  assign out_hs = bus.res_tvalid && bus.res_tready;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign beat_accept[b] = in_hs && (ip == 1'(b));
    assign res_accept[b]  = out_hs && (op == 1'(b));

    lsf_hist_bank_ctrl #(
      .RBINS     (RBINS),
      .EVT_W     (EVT_W),
      .DRAIN_CYC (DRAIN_CYC),
      .TIMEOUT   (TIMEOUT)
    ) u_bank (
      .clk           (clk),
      .rst           (rst),
      .beat_accept   (beat_accept[b]),
      .beat_data     (bus.s_bin_tdata),
      .beat_last     (bus.s_bin_tlast),
      .evt_id        (bus.s_evt_id),
      .res_accept    (res_accept[b]),
      .max_rbin      (hist_max_rbin[b]),
      .max_count     (hist_max_count[b]),
      .max_vld       (hist_max_vld[b]),
      .bin_tdata     (hist_bin_tdata[b]),
      .bin_tvalid    (hist_bin_tvalid[b]),
      .enable        (hist_enable[b]),
      .reset_rbins   (hist_reset_rbins[b]),
      .in_ready      (bank_ready[b]),
      .done          (bank_done[b]),
      .timeout_close (bank_tclose[b]),
      .result        (bank_res[b])
    );
  end

  // Input pointer moves on when the current event closes, by tlast or by timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      ip <= 1'b0;
    end else if ((in_hs && bus.s_bin_tlast) || bank_tclose[ip]) begin
      ip <= ~ip;
    end
  end

  // Output pointer moves on after each accepted result.
  always_ff @(posedge clk) begin
    if (rst) begin
      op <= 1'b0;
    end else if (out_hs) begin
      op <= ~op;
    end
  end

  // Present the selected bank's held result; it stays put until accepted.
  always_comb begin
    bus.res_tvalid  = bank_done[op];
    bus.res_evt_id  = EVT_W'(bank_res[op].evt_id);
    bus.res_rbin    = bank_res[op].rbin;
    bus.res_count   = bank_res[op].count;
    bus.res_timeout = bank_res[op].timeout;
  end

endmodule

// File: tb/tb_lsf_hist_scheduler.sv
// Directed bench for lsf_hist_scheduler with a behavioural model of the two histogram banks.
// Build with LSF_HIST_TIMEOUT_EN defined to exercise the idle force-close path.
module tb_lsf_hist_scheduler;
  import lsf_hist_sched_pkg::*;

  localparam int RBINS     = 128;
  localparam int EVT_W     = 12;
  localparam int DRAIN_CYC = 5;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lsf_hist_scheduler_if #(.EVT_W(EVT_W)) bus ();

  logic [1:0][7:0] hist_bin_tdata;
  logic [1:0]      hist_bin_tvalid;
  logic [1:0]      hist_enable;
  logic [1:0]      hist_reset_rbins;
  logic [1:0][6:0] hist_max_rbin;
  logic [1:0][3:0] hist_max_count;
  logic [1:0]      hist_max_vld;

  lsf_hist_scheduler #(
    .RBINS     (RBINS),
    .EVT_W     (EVT_W),
    .DRAIN_CYC (DRAIN_CYC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .hist_bin_tdata   (hist_bin_tdata),
    .hist_bin_tvalid  (hist_bin_tvalid),
    .hist_enable      (hist_enable),
    .hist_reset_rbins (hist_reset_rbins),
    .hist_max_rbin    (hist_max_rbin),
    .hist_max_count   (hist_max_count),
    .hist_max_vld     (hist_max_vld)
  );

  // Bank model: per-bin hit counters and a running maximum, first bin wins ties.
  for (genvar g = 0; g < 2; g++) begin : g_model
    logic [3:0] cnt [RBINS];
    logic [6:0] mrbin = '0;
    logic [3:0] mcnt  = '0;
    logic       mvld  = 1'b0;
    logic       hit;
    logic [6:0] idx;
    logic [3:0] nc;

    assign hit = hist_enable[g] && hist_bin_tvalid[g] && !hist_bin_tdata[g][7];
    assign idx = hist_bin_tdata[g][6:0];
    assign nc  = cnt[idx] + 4'd1;

    // Clear while reset_rbins is high, otherwise count hits and flag a new maximum.
    always_ff @(posedge clk) begin
      if (hist_reset_rbins[g]) begin
        for (int i = 0; i < RBINS; i++) cnt[i] <= '0;
        mrbin <= '0;
        mcnt  <= '0;
        mvld  <= 1'b0;
      end else begin
        mvld <= 1'b0;
        if (hit) begin
          cnt[idx] <= nc;
          if (nc > mcnt) begin
            mrbin <= idx;
            mcnt  <= nc;
            mvld  <= 1'b1;
          end
        end
      end
    end

    assign hist_max_rbin[g]  = mrbin;
    assign hist_max_count[g] = mcnt;
    assign hist_max_vld[g]   = mvld;
  end

  int vectors     = 0;
  int miscompares = 0;
  int got_cnt     = 0;
  int n_ready     = 0;
  int n_clear     = 0;
  int stalls      = 0;
  int stall_sum   = 0;

  logic [11:0] r_id   [4];
  logic [6:0]  r_rbin [4];
  logic [3:0]  r_cnt  [4];
  logic        r_to   [4];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one beat from a negedge and return at the negedge after it is accepted.
  task automatic applyStimulus(input logic [7:0] d, input logic l, input logic [11:0] id,
                               output int stall_cnt);
    stall_cnt        = 0;
    bus.s_bin_tdata  = d;
    bus.s_bin_tlast  = l;
    bus.s_evt_id     = id;
    bus.s_bin_tvalid = 1'b1;
    while (!bus.s_bin_tready && stall_cnt < 1000) begin
      @(negedge clk);
      stall_cnt++;
    end
    checkOutput("beat_accept", bus.s_bin_tready, 1'b1);
    @(negedge clk);
    bus.s_bin_tvalid = 1'b0;
    bus.s_bin_tlast  = 1'b0;
  endtask

  // Record results seen on the output; drop a pending input beat once it is taken.
  task automatic collectResults(input int want, input int budget);
    bit taken = 1'b0;
    got_cnt = 0;
    for (int c = 0; c < budget && got_cnt < want; c++) begin
      if (bus.s_bin_tvalid && bus.s_bin_tready) taken = 1'b1;
      if (bus.res_tvalid && bus.res_tready) begin
        r_id[got_cnt]   = bus.res_evt_id;
        r_rbin[got_cnt] = bus.res_rbin;
        r_cnt[got_cnt]  = bus.res_count;
        r_to[got_cnt]   = bus.res_timeout;
        got_cnt++;
      end
      @(negedge clk);
      if (taken) bus.s_bin_tvalid = 1'b0;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    bus.s_bin_tvalid = 1'b0;
    bus.s_bin_tlast  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic waitReady();
    for (int c = 0; c < 400 && !bus.s_bin_tready; c++) @(negedge clk);
    checkOutput("wait_ready", bus.s_bin_tready, 1'b1);
  endtask

  // Directed sequence.
  initial begin
    bus.s_bin_tdata  = '0;
    bus.s_bin_tvalid = 1'b0;
    bus.s_bin_tlast  = 1'b0;
    bus.s_evt_id     = '0;
    bus.res_tready   = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] reset state and clear timing");
    checkOutput("rst_tready", bus.s_bin_tready, 1'b0);
    checkOutput("rst_hist_tvalid", hist_bin_tvalid, 2'b00);
    checkOutput("rst_enable", hist_enable, 2'b00);
    checkOutput("rst_reset_rbins", hist_reset_rbins, 2'b00);
    checkOutput("rst_res_tvalid", bus.res_tvalid, 1'b0);
    checkOutput("rst_res_count", bus.res_count, 4'd0);
    checkOutput("rst_res_evt", bus.res_evt_id, 12'd0);
    rst = 1'b0;
    checkOutput("prep_reset_rbins", hist_reset_rbins, 2'b00);
    checkOutput("prep_enable", hist_enable, 2'b00);
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk);
      #1;
      if (hist_reset_rbins[0]) n_clear++;
      if (bus.s_bin_tready) begin
        n_ready = c;
        break;
      end
    end
    // The PREP cycle before the first edge is cycle 1.
    checkOutput("ready_cycle", n_ready + 1, RBINS + 4);
    checkOutput("clear_len", n_clear, RBINS + 2);
    @(negedge clk);

    $display("[TB] single event 0x005");
    bus.res_tready = 1'b1;
    applyStimulus(8'h03, 1'b0, 12'h005, stalls);
    applyStimulus(8'h07, 1'b0, 12'h005, stalls);
    applyStimulus(8'h07, 1'b0, 12'h005, stalls);
    applyStimulus(8'h07, 1'b0, 12'h005, stalls);
    applyStimulus(8'h09, 1'b1, 12'h005, stalls);
    for (int c = 0; c < 50 && !bus.res_tvalid; c++) @(negedge clk);
    checkOutput("e5_valid", bus.res_tvalid, 1'b1);
    checkOutput("e5_evt", bus.res_evt_id, 12'h005);
    checkOutput("e5_rbin", bus.res_rbin, 7'd7);
    checkOutput("e5_count", bus.res_count, 4'd3);
    checkOutput("e5_timeout", bus.res_timeout, 1'b0);
    @(negedge clk);
    checkOutput("e5_single_beat", bus.res_tvalid, 1'b0);
    @(negedge clk);
    checkOutput("e5_reclear", hist_reset_rbins[0], 1'b1);

    $display("[TB] back-to-back events");
    doReset();
    waitReady();
    stall_sum = 0;
    applyStimulus(8'h01, 1'b0, 12'h0A1, stalls);
    stall_sum += stalls;
    applyStimulus(8'h01, 1'b1, 12'h0A1, stalls);
    stall_sum += stalls;
    checkOutput("a_on_bank0", {hist_bin_tvalid[0], hist_bin_tdata[0]}, {1'b1, 8'h01});
    applyStimulus(8'h02, 1'b1, 12'h0B2, stalls);
    stall_sum += stalls;
    checkOutput("b_on_bank1", {hist_bin_tvalid[1], hist_bin_tdata[1]}, {1'b1, 8'h02});
    checkOutput("b2b_stalls", stall_sum, 0);
    collectResults(2, 100);
    checkOutput("b2b_results", got_cnt, 2);
    checkOutput("a_evt", r_id[0], 12'h0A1);
    checkOutput("a_rbin", r_rbin[0], 7'd1);
    checkOutput("a_count", r_cnt[0], 4'd2);
    checkOutput("b_evt", r_id[1], 12'h0B2);
    checkOutput("b_rbin", r_rbin[1], 7'd2);
    checkOutput("b_count", r_cnt[1], 4'd1);

    $display("[TB] backpressure over three events");
    doReset();
    waitReady();
    bus.res_tready = 1'b0;
    applyStimulus(8'h05, 1'b0, 12'h011, stalls);
    applyStimulus(8'h05, 1'b1, 12'h011, stalls);
    applyStimulus(8'h06, 1'b1, 12'h022, stalls);
    checkOutput("stall_after_e2", bus.s_bin_tready, 1'b0);
    bus.s_bin_tdata  = 8'h08;
    bus.s_bin_tlast  = 1'b1;
    bus.s_evt_id     = 12'h033;
    bus.s_bin_tvalid = 1'b1;
    for (int c = 0; c < 30 && !bus.res_tvalid; c++) @(negedge clk);
    checkOutput("e1_valid", bus.res_tvalid, 1'b1);
    for (int k = 0; k < 4; k++) begin
      checkOutput("hold_evt", bus.res_evt_id, 12'h011);
      checkOutput("hold_count", bus.res_count, 4'd2);
      checkOutput("hold_tready", bus.s_bin_tready, 1'b0);
      @(negedge clk);
    end
    bus.res_tready = 1'b1;
    collectResults(3, 400);
    bus.s_bin_tlast = 1'b0;
    checkOutput("bp_results", got_cnt, 3);
    checkOutput("bp_evt0", r_id[0], 12'h011);
    checkOutput("bp_rbin0", r_rbin[0], 7'd5);
    checkOutput("bp_count0", r_cnt[0], 4'd2);
    checkOutput("bp_evt1", r_id[1], 12'h022);
    checkOutput("bp_rbin1", r_rbin[1], 7'd6);
    checkOutput("bp_evt2", r_id[2], 12'h033);
    checkOutput("bp_rbin2", r_rbin[2], 7'd8);
    checkOutput("bp_count2", r_cnt[2], 4'd1);

    $display("[TB] invalid-only event and abort");
    doReset();
    waitReady();
    applyStimulus(8'h80, 1'b0, 12'h0AB, stalls);
    applyStimulus(8'h85, 1'b1, 12'h0AB, stalls);
    collectResults(1, 50);
    checkOutput("inv_results", got_cnt, 1);
    checkOutput("inv_evt", r_id[0], 12'h0AB);
    checkOutput("inv_rbin", r_rbin[0], 7'd0);
    checkOutput("inv_count", r_cnt[0], 4'd0);
    applyStimulus(8'h03, 1'b0, 12'h0CD, stalls);
    applyStimulus(8'h04, 1'b0, 12'h0CD, stalls);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_tready", bus.s_bin_tready, 1'b0);
    checkOutput("abort_hist_tvalid", hist_bin_tvalid, 2'b00);
    checkOutput("abort_enable", hist_enable, 2'b00);
    checkOutput("abort_reset_rbins", hist_reset_rbins, 2'b00);
    checkOutput("abort_res_tvalid", bus.res_tvalid, 1'b0);
    checkOutput("abort_res_evt", bus.res_evt_id, 12'd0);
    checkOutput("abort_res_rbin", bus.res_rbin, 7'd0);
    checkOutput("abort_res_count", bus.res_count, 4'd0);
    checkOutput("abort_res_timeout", bus.res_timeout, 1'b0);
    rst = 1'b0;
    waitReady();
    collectResults(1, 60);
    checkOutput("abort_no_result", got_cnt, 0);

`ifdef LSF_HIST_TIMEOUT_EN
    $display("[TB] idle timeout closes event");
    doReset();
    waitReady();
    applyStimulus(8'h04, 1'b0, 12'h0EE, stalls);
    collectResults(1, 60);
    checkOutput("to_results", got_cnt, 1);
    checkOutput("to_evt", r_id[0], 12'h0EE);
    checkOutput("to_rbin", r_rbin[0], 7'd4);
    checkOutput("to_count", r_cnt[0], 4'd1);
    checkOutput("to_flag", r_to[0], 1'b1);
`else
    $display("[TB] fill waits without tlast");
    doReset();
    waitReady();
    applyStimulus(8'h04, 1'b0, 12'h0EE, stalls);
    collectResults(1, 40);
    checkOutput("wait_no_result", got_cnt, 0);
    checkOutput("wait_still_ready", bus.s_bin_tready, 1'b1);
    applyStimulus(8'h04, 1'b1, 12'h0EE, stalls);
    collectResults(1, 40);
    checkOutput("wait_results", got_cnt, 1);
    checkOutput("wait_rbin", r_rbin[0], 7'd4);
    checkOutput("wait_count", r_cnt[0], 4'd2);
    checkOutput("wait_timeout", r_to[0], 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
